fr_ingr_protocol_checker: RTL and testbench

//  Passive in-line checker for the ingress req/resp/data AXI-Stream triplet of filter_resize.

---
 rtl/fr_ingr_protocol_checker.sv | 213 +++++++++++++++++++++
 tb/tb_fr_ingr_protocol_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fr_ingr_protocol_checker.sv
// ---------------------------------------------------------------------------
// fr_ingr_protocol_checker
//   Passive in-line checker for the ingress req/resp/data AXI-Stream triplet
//   of filter_resize. It tracks up to REQ_DEPTH outstanding requests and a
//   data-beat credit, and reports 16 fault bits per cycle, one cycle after
//   the offending handshake. Sticky, first-error and saturating-count views
//   of the faults are kept until reset or err_clear.
//
// Ports
//   ap_clk, ap_rst_n          clock, async active-low reset
//   req_*  (tvalid/tready/tdata[63:0])   request channel (monitored only)
//   resp_* (tvalid/tready/tdata[63:0])   response channel (monitored only)
//   data_* (tvalid/tready/tdata[DATA_W]) data channel (monitored only)
//     tdata layout for req/resp: [63:48] burst_length, [47:32] channel,
//                                [1] eof, [0] sof
//   err_clear                 sync clear of sticky/first/count
//   protocol_error[15:0]      per-cycle fault bits (registered)
//   protocol_error_ap_vld     protocol_error != 0
//   error_sticky[15:0]        OR of faults since reset/clear
//   error_first[15:0]         faults of the first faulting cycle
//   error_count[CNT_W-1:0]    number of faulting cycles, saturating
//   outstanding_req           request FIFO occupancy
//
// Fault bits: 0 ch mismatch, 1 resp burst > req, 2 sof mismatch,
//   3 eof mismatch, 4/5/10 req/resp/data stability, 6 req FIFO overflow,
//   7 resp without req, 8 burst > MAX_BURST, 9 data without credit,
//   12 req burst == 0, 13 strict length mismatch; 11/14/15 unused.
// ---------------------------------------------------------------------------
module fr_ingr_protocol_checker #(
    parameter int          REQ_DEPTH  = 8,
    parameter logic [15:0] MAX_BURST  = 16'd4096,
    parameter int          DATA_W     = 32,
    parameter bit          STRICT_LEN = 1'b1,
    parameter int          CNT_W      = 16,
    localparam int         OCC_W      = $clog2(REQ_DEPTH + 1),
    localparam int         PTR_W      = $clog2(REQ_DEPTH)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              req_tready,
    input  logic              req_tvalid,
    input  logic [63:0]       req_tdata,
    input  logic              resp_tready,
    input  logic              resp_tvalid,
    input  logic [63:0]       resp_tdata,
    input  logic              data_tready,
    input  logic              data_tvalid,
    input  logic [DATA_W-1:0] data_tdata,
    input  logic              err_clear,
    output logic [15:0]       protocol_error,
    output logic              protocol_error_ap_vld,
    output logic [15:0]       error_sticky,
    output logic [15:0]       error_first,
    output logic [CNT_W-1:0]  error_count,
    output logic [OCC_W-1:0]  outstanding_req
);

    typedef struct packed {
        logic [15:0] ch;
        logic [15:0] burst;
        logic        sof;
        logic        eof;
    } req_entry_t;

    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(REQ_DEPTH);

    function automatic req_entry_t unpack_hdr(input logic [63:0] tdata);
        unpack_hdr = '{ch: tdata[47:32], burst: tdata[63:48], sof: tdata[0], eof: tdata[1]};
    endfunction

    req_entry_t             fifo_mem [REQ_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [23:0]            credit_q, credit_d;
    logic                   req_stall_q, resp_stall_q, data_stall_q;
    logic [63:0]            req_hold_q, resp_hold_q;
    logic [DATA_W-1:0]      data_hold_q;
    logic [15:0]            perr_q, sticky_q, sticky_d, first_q, first_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    req_entry_t             req_hdr, resp_hdr, ref_hdr;
    logic                   req_hs, resp_hs, data_hs, fifo_empty, fifo_full;
    logic                   req_len_ok, resp_taken, push, pop, bypass;
    logic [15:0]            fault;
    logic [24:0]            credit_sum;
    logic [23:0]            credit_plus;

    assign req_hs     = req_tvalid & req_tready;
    assign resp_hs    = resp_tvalid & resp_tready;
    assign data_hs    = data_tvalid & data_tready;
    assign req_hdr    = unpack_hdr(req_tdata);
    assign resp_hdr   = unpack_hdr(resp_tdata);
    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == FULL_OCC);
    assign req_len_ok = (req_hdr.burst != 16'd0) && (req_hdr.burst <= MAX_BURST);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        fault       = '0;
        resp_taken  = 1'b0;
        push        = 1'b0;
        ref_hdr     = fifo_empty ? req_hdr : fifo_mem[rd_ptr_q];
        credit_sum  = {1'b0, credit_q};

        if (req_hs) begin
            if (req_hdr.burst == 16'd0)       fault[12] = 1'b1;
            else if (req_hdr.burst > MAX_BURST) fault[8] = 1'b1;
        end

        // Zero-length responses carry no information and are ignored.
        if (resp_hs && (resp_hdr.burst != 16'd0)) begin
            if (fifo_empty && !(req_hs && req_len_ok)) begin
                fault[7] = 1'b1;
            end else begin
                resp_taken = 1'b1;
                fault[0]   = (resp_hdr.ch != ref_hdr.ch);
                fault[1]   = (resp_hdr.burst > ref_hdr.burst);
                fault[2]   = (resp_hdr.sof != ref_hdr.sof);
                fault[3]   = (resp_hdr.eof != ref_hdr.eof);
                fault[13]  = STRICT_LEN && (resp_hdr.burst != ref_hdr.burst);
                credit_sum = {1'b0, credit_q} + 25'(resp_hdr.burst);
            end
        end

        // An empty FIFO plus a same-cycle req means the resp consumes the req
        // directly; nothing is pushed or popped.
        pop    = resp_taken && !fifo_empty;
        bypass = resp_taken && fifo_empty;

        // The pop is credited before the push, so full+push+pop is legal.
        if (req_hs && req_len_ok && !bypass) begin
            if (fifo_full && !pop) fault[6] = 1'b1;
            else                   push     = 1'b1;
        end

        credit_plus = credit_sum[24] ? 24'hFF_FFFF : credit_sum[23:0];
        credit_d    = credit_plus;
        if (data_hs) begin
            if (credit_plus == '0) fault[9] = 1'b1;
            else                   credit_d = credit_plus - 24'd1;
        end

        fault[4]  = req_stall_q  && (!req_tvalid  || (req_tdata  != req_hold_q));
        fault[5]  = resp_stall_q && (!resp_tvalid || (resp_tdata != resp_hold_q));
        fault[10] = data_stall_q && (!data_tvalid || (data_tdata != data_hold_q));

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    // err_clear applies first, then this cycle's faults are recorded.
    always_comb begin
        sticky_d = (err_clear ? 16'd0 : sticky_q) | fault;
        first_d  = err_clear ? 16'd0 : first_q;
        cnt_d    = err_clear ? '0 : cnt_q;
        if (fault != 16'd0) begin
            if ((err_clear ? 16'd0 : sticky_q) == 16'd0) first_d = fault;
            if (cnt_d != '1)                              cnt_d   = cnt_d + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            credit_q     <= '0;
            req_stall_q  <= 1'b0;
            resp_stall_q <= 1'b0;
            data_stall_q <= 1'b0;
            req_hold_q   <= '0;
            resp_hold_q  <= '0;
            data_hold_q  <= '0;
            perr_q       <= '0;
            sticky_q     <= '0;
            first_q      <= '0;
            cnt_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            credit_q     <= credit_d;
            req_stall_q  <= req_tvalid & ~req_tready;
            resp_stall_q <= resp_tvalid & ~resp_tready;
            data_stall_q <= data_tvalid & ~data_tready;
            req_hold_q   <= req_tdata;
            resp_hold_q  <= resp_tdata;
            data_hold_q  <= data_tdata;
            perr_q       <= fault;
            sticky_q     <= sticky_d;
            first_q      <= first_d;
            cnt_q        <= cnt_d;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy gates every read, so stale
    // entries are never observed and the array can map to plain RAM.
    always_ff @(posedge ap_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= req_hdr;
    end

    assign protocol_error        = perr_q;
    assign protocol_error_ap_vld = (perr_q != 16'd0);
    assign error_sticky          = sticky_q;
    assign error_first           = first_q;
    assign error_count           = cnt_q;
    assign outstanding_req       = occ_q;

endmodule

// File: tb/tb_fr_ingr_protocol_checker.sv
// ---------------------------------------------------------------------------
// tb_fr_ingr_protocol_checker
//   Self-checking bench for fr_ingr_protocol_checker. Each driven cycle pushes
//   its expected fault word onto a scoreboard queue; the word is popped and
//   compared against protocol_error/ap_vld one cycle later.
// ---------------------------------------------------------------------------
module tb_fr_ingr_protocol_checker;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int OCC_W  = 4;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              req_tready, req_tvalid;
    logic [63:0]       req_tdata;
    logic              resp_tready, resp_tvalid;
    logic [63:0]       resp_tdata;
    logic              data_tready, data_tvalid;
    logic [DATA_W-1:0] data_tdata;
    logic              err_clear;
    logic [15:0]       protocol_error;
    logic              protocol_error_ap_vld;
    logic [15:0]       error_sticky, error_first;
    logic [CNT_W-1:0]  error_count;
    logic [OCC_W-1:0]  outstanding_req;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] exp_q[$];

    fr_ingr_protocol_checker #(
        .REQ_DEPTH(8), .MAX_BURST(16'd4096), .DATA_W(DATA_W),
        .STRICT_LEN(1'b1), .CNT_W(CNT_W)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_tready(req_tready), .req_tvalid(req_tvalid), .req_tdata(req_tdata),
        .resp_tready(resp_tready), .resp_tvalid(resp_tvalid), .resp_tdata(resp_tdata),
        .data_tready(data_tready), .data_tvalid(data_tvalid), .data_tdata(data_tdata),
        .err_clear(err_clear),
        .protocol_error(protocol_error), .protocol_error_ap_vld(protocol_error_ap_vld),
        .error_sticky(error_sticky), .error_first(error_first),
        .error_count(error_count), .outstanding_req(outstanding_req)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mk(input int burst, input int ch, input bit eof, input bit sof);
        mk = {16'(burst), 16'(ch), 30'd0, eof, sof};
    endfunction

    task automatic idle();
        req_tvalid  = 1'b0; req_tready  = 1'b1;
        resp_tvalid = 1'b0; resp_tready = 1'b1;
        data_tvalid = 1'b0; data_tready = 1'b1;
        err_clear   = 1'b0;
    endtask

    // One clock: record expectation for the current inputs, then compare the
    // registered result just after the edge.
    task automatic step(input logic [15:0] exp);
        logic [15:0] e;
        exp_q.push_back(exp);
        @(posedge ap_clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("protocol_error", protocol_error, e);
            check("ap_vld", protocol_error_ap_vld, (e != 16'd0));
        end
    endtask

    task automatic send_req(input logic [63:0] td);
        req_tvalid = 1'b1; req_tready = 1'b1; req_tdata = td;
    endtask

    task automatic send_resp(input logic [63:0] td);
        resp_tvalid = 1'b1; resp_tready = 1'b1; resp_tdata = td;
    endtask

    task automatic clear_errors();
        idle();
        err_clear = 1'b1;
        step(16'h0000);
        err_clear = 1'b0;
        check("clr_sticky", error_sticky, 0);
        check("clr_first", error_first, 0);
        check("clr_count", error_count, 0);
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        req_tdata  = '0;
        resp_tdata = '0;
        data_tdata = '0;
        idle();
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_perr", protocol_error, 0);
        check("rst_vld", protocol_error_ap_vld, 0);
        check("rst_sticky", error_sticky, 0);
        check("rst_first", error_first, 0);
        check("rst_count", error_count, 0);
        check("rst_occ", outstanding_req, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Clean transaction, then one data beat too many.
        send_req(mk(4, 3, 1, 1));
        step(16'h0000);
        check("occ_after_req", outstanding_req, 1);
        idle(); send_resp(mk(4, 3, 1, 1));
        step(16'h0000);
        check("occ_after_resp", outstanding_req, 0);
        idle(); data_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_tdata = 32'(i);
            step(16'h0000);
        end
        step(16'h0200);
        check("nocredit_sticky", error_sticky, 16'h0200);
        clear_errors();

        // Channel mismatch.
        send_req(mk(4, 3, 1, 1));
        step(16'h0000);
        idle(); send_resp(mk(4, 5, 1, 1));
        step(16'h0001);
        check("ch_sticky", error_sticky, 16'h0001);
        check("ch_first", error_first, 16'h0001);
        check("ch_count", error_count, 1);
        clear_errors();

        // Overflow on the ninth req, underflow on the ninth resp.
        for (int i = 0; i < 8; i++) begin
            send_req(mk(4, i, 0, 1));
            step(16'h0000);
        end
        check("occ_full", outstanding_req, 8);
        send_req(mk(4, 8, 0, 1));
        step(16'h0040);
        check("occ_overflow", outstanding_req, 8);
        idle();
        for (int i = 0; i < 8; i++) begin
            send_resp(mk(4, i, 0, 1));
            step(16'h0000);
        end
        send_resp(mk(4, 8, 0, 1));
        step(16'h0080);
        check("occ_drained", outstanding_req, 0);
        check("ovf_first", error_first, 16'h0040);
        check("ovf_sticky", error_sticky, 16'h00C0);
        check("ovf_count", error_count, 2);
        clear_errors();

        // Push and pop together while full.
        for (int i = 0; i < 8; i++) begin
            send_req(mk(4, i, 1, 0));
            step(16'h0000);
        end
        send_req(mk(4, 8, 1, 0));
        send_resp(mk(4, 0, 1, 0));
        step(16'h0000);
        check("occ_full_pushpop", outstanding_req, 8);
        idle();
        for (int i = 1; i <= 8; i++) begin
            send_resp(mk(4, i, 1, 0));
            step(16'h0000);
        end
        check("occ_after_pushpop", outstanding_req, 0);

        // Length boundaries and strict-length check.
        idle(); send_req(mk(0, 1, 1, 1));
        step(16'h1000);
        send_req(mk(4097, 1, 1, 1));
        step(16'h0100);
        check("occ_badlen", outstanding_req, 0);
        send_req(mk(4096, 2, 1, 1));
        step(16'h0000);
        check("occ_maxlen", outstanding_req, 1);
        idle(); send_resp(mk(2, 2, 1, 1));
        step(16'h2000);
        check("occ_strict", outstanding_req, 0);
        send_resp(mk(0, 7, 0, 0));
        step(16'h0000);

        // Same-cycle req/resp bypass on an empty FIFO.
        idle(); send_req(mk(4, 9, 1, 1)); send_resp(mk(4, 9, 1, 1));
        step(16'h0000);
        check("occ_bypass", outstanding_req, 0);

        // Stability violations on each channel.
        idle();
        req_tvalid = 1'b1; req_tready = 1'b0; req_tdata = mk(4, 10, 1, 1);
        step(16'h0000);
        req_tdata = mk(4, 11, 1, 1);
        step(16'h0010);
        req_tready = 1'b1;
        step(16'h0000);
        check("occ_stable_req", outstanding_req, 1);
        idle(); send_resp(mk(4, 11, 1, 1));
        step(16'h0000);
        idle(); resp_tvalid = 1'b1; resp_tready = 1'b0; resp_tdata = mk(4, 0, 0, 0);
        step(16'h0000);
        idle();
        step(16'h0020);
        data_tvalid = 1'b1; data_tready = 1'b0; data_tdata = 32'hA5A5_0001;
        step(16'h0000);
        idle();
        step(16'h0400);
        step(16'h0000);
        clear_errors();

        // Fault coinciding with err_clear.
        send_req(mk(4097, 1, 0, 0));
        step(16'h0100);
        err_clear = 1'b1; send_req(mk(0, 1, 0, 0));
        step(16'h1000);
        err_clear = 1'b0;
        check("clrfault_sticky", error_sticky, 16'h1000);
        check("clrfault_first", error_first, 16'h1000);
        check("clrfault_count", error_count, 1);

        // Counter saturation.
        for (int i = 0; i < 70000; i++) step(16'h1000);
        check("count_saturated", error_count, 16'hFFFF);
        idle();
        step(16'h0000);
        check("count_hold", error_count, 16'hFFFF);

        // Async reset in the middle of tracking.
        send_req(mk(4, 1, 1, 1));
        step(16'h0000);
        step(16'h0000);
        check("occ_pre_reset", outstanding_req, 2);
        idle();
        #2 ap_rst_n = 1'b0;
        #1;
        check("mid_rst_occ", outstanding_req, 0);
        check("mid_rst_count", error_count, 0);
        check("mid_rst_sticky", error_sticky, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        send_resp(mk(4, 1, 1, 1));
        step(16'h0080);
        idle();
        step(16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
